vga_timing_gen: RTL and testbench

- Parametrised two-axis VGA timing generator: horizontal pixel counter plus vertical line counter.
- Produces hsync, vsync, active-video, pixel coordinates and line/frame start strobes.
- Sits between the pixel clock domain and the pixel/framebuffer fetch logic.
- Adds a pixel clock-enable, a vertical axis, programmable sync polarity and frame strobes.

---
 rtl/vga_timing_gen.sv | 92 +++++++++
 tb/tb_vga_timing_gen.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// Two-axis VGA timing generator: pixel/line counters with registered
// sync, active-video, coordinates and line/frame start strobes.
module vga_timing_gen #(
  parameter int H_VISIBLE = 800,
  parameter int H_FRONT   = 56,
  parameter int H_SYNC    = 120,
  parameter int H_BACK    = 64,
  parameter int V_VISIBLE = 600,
  parameter int V_FRONT   = 37,
  parameter int V_SYNC    = 6,
  parameter int V_BACK    = 23,
  parameter bit HS_POL    = 1'b1,
  parameter bit VS_POL    = 1'b1,
  parameter int CW        = 12
) (
  input  logic          ck,
  input  logic          reset,
  input  logic          en,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          active,
  output logic          hsync,
  output logic          vsync,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_VIS  = CW'(H_VISIBLE);
  localparam logic [CW-1:0] V_VIS  = CW'(V_VISIBLE);
  localparam logic [CW-1:0] H_SS   = CW'(H_VISIBLE + H_FRONT);
  localparam logic [CW-1:0] H_SE   = CW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CW-1:0] V_SS   = CW'(V_VISIBLE + V_FRONT);
  localparam logic [CW-1:0] V_SE   = CW'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [CW-1:0] r_h;
  logic [CW-1:0] r_v;

  logic [CW-1:0] w_h_nxt;
  logic [CW-1:0] w_v_nxt;
  logic          w_h_wrap;
  logic          w_v_wrap;
  logic          w_h_vis;
  logic          w_v_vis;
  logic          w_hs_on;
  logic          w_vs_on;

  assign w_h_wrap = (r_h == H_LAST);
  assign w_v_wrap = (r_v == V_LAST);
  assign w_h_nxt  = w_h_wrap ? '0 : r_h + CW'(1);
  assign w_v_nxt  = !w_h_wrap ? r_v
                  : (w_v_wrap ? '0 : r_v + CW'(1));

  // Outputs are decoded from the next counter state so they land
  // on the same edge as the counters themselves.
  assign w_h_vis = (w_h_nxt < H_VIS);
  assign w_v_vis = (w_v_nxt < V_VIS);
  assign w_hs_on = (w_h_nxt >= H_SS) && (w_h_nxt < H_SE);
  assign w_vs_on = (w_v_nxt >= V_SS) && (w_v_nxt < V_SE);

  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      r_h         <= H_LAST;
      r_v         <= V_LAST;
      x           <= '0;
      y           <= '0;
      active      <= 1'b0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (en) begin
      r_h         <= w_h_nxt;
      r_v         <= w_v_nxt;
      x           <= (w_h_vis && w_v_vis) ? w_h_nxt : '0;
      y           <= w_v_vis ? w_v_nxt : '0;
      active      <= w_h_vis && w_v_vis;
      hsync       <= w_hs_on ? HS_POL : ~HS_POL;
      vsync       <= w_vs_on ? VS_POL : ~VS_POL;
      line_start  <= (w_h_nxt == '0);
      frame_start <= (w_h_nxt == '0) && (w_v_nxt == '0);
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default and small-parameter instances
// checked every pixel clock against a linear-position reference model.
module tb_vga_timing_gen;

  localparam int T0_H = 800 + 56 + 120 + 64;
  localparam int T0   = T0_H * (600 + 37 + 6 + 23);
  localparam int T1_H = 4 + 1 + 2 + 1;
  localparam int T1   = T1_H * (3 + 1 + 1 + 1);

  logic ck = 1'b0;
  always #5 ck = ~ck;

  logic        rst0, en0, rst1, en1;
  logic [11:0] x0, y0;
  logic        act0, hs0, vs0, ls0, fs0;
  logic [3:0]  x1, y1;
  logic        act1, hs1, vs1, ls1, fs1;

  vga_timing_gen u_dut0 (
    .ck(ck), .reset(rst0), .en(en0),
    .x(x0), .y(y0), .active(act0),
    .hsync(hs0), .vsync(vs0),
    .line_start(ls0), .frame_start(fs0)
  );

  vga_timing_gen #(
    .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .CW(4)
  ) u_dut1 (
    .ck(ck), .reset(rst1), .en(en1),
    .x(x1), .y(y1), .active(act1),
    .hsync(hs1), .vsync(vs1),
    .line_start(ls1), .frame_start(fs1)
  );

  int checks = 0;
  int errors = 0;

  int pos0, pos1;
  bit stb0, stb1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Position is the pixel index within the frame; h/v fall out of it.
  function automatic logic [28:0] ref_out(
    input int hv, hf, hs, hb, vv, vf, vs,
    input bit hp, vp,
    input int pos, input bit stb);
    int ht, h, v;
    logic [11:0] ex, ey;
    logic ea, ehs, evs, els, efs;
    ht  = hv + hf + hs + hb;
    h   = pos % ht;
    v   = pos / ht;
    ea  = (h < hv) && (v < vv);
    ex  = ea ? 12'(h) : 12'd0;
    ey  = (v < vv) ? 12'(v) : 12'd0;
    ehs = (h >= hv + hf && h < hv + hf + hs) ? hp : ~hp;
    evs = (v >= vv + vf && v < vv + vf + vs) ? vp : ~vp;
    els = stb && (h == 0);
    efs = stb && (pos == 0);
    return {ex, ey, ea, ehs, evs, els, efs};
  endfunction

  task automatic cmp(input string tag,
                     input logic [28:0] o,
                     input logic [28:0] e);
    chk({tag, ".x"},   32'(o[28:17]), 32'(e[28:17]));
    chk({tag, ".y"},   32'(o[16:5]),  32'(e[16:5]));
    chk({tag, ".act"}, 32'(o[4]),     32'(e[4]));
    chk({tag, ".hs"},  32'(o[3]),     32'(e[3]));
    chk({tag, ".vs"},  32'(o[2]),     32'(e[2]));
    chk({tag, ".ls"},  32'(o[1]),     32'(e[1]));
    chk({tag, ".fs"},  32'(o[0]),     32'(e[0]));
  endtask

  task automatic cmp_all(input string tag);
    cmp({tag, "0"}, {x0, y0, act0, hs0, vs0, ls0, fs0},
        ref_out(800, 56, 120, 64, 600, 37, 6, 1'b1, 1'b1,
                pos0, stb0));
    cmp({tag, "1"}, {8'd0, x1, 8'd0, y1, act1, hs1, vs1, ls1, fs1},
        ref_out(4, 1, 2, 1, 3, 1, 1, 1'b0, 1'b0, pos1, stb1));
  endtask

  task automatic step();
    @(posedge ck);
    if (!rst0) begin
      stb0 = en0;
      if (en0) pos0 = (pos0 + 1) % T0;
    end
    if (!rst1) begin
      stb1 = en1;
      if (en1) pos1 = (pos1 + 1) % T1;
    end
    @(negedge ck);
    cmp_all("cyc");
  endtask

  // Called at a negedge: pulse reset well clear of any clock edge.
  task automatic async_rst(input bit d0, input bit d1);
    if (d0) rst0 = 1'b1;
    if (d1) rst1 = 1'b1;
    #1;
    if (d0) begin pos0 = T0 - 1; stb0 = 1'b0; end
    if (d1) begin pos1 = T1 - 1; stb1 = 1'b0; end
    cmp_all("arst");
    rst0 = 1'b0;
    rst1 = 1'b0;
    #1;
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b1;
    en0  = 1'b0; en1  = 1'b0;
    pos0 = T0 - 1; pos1 = T1 - 1;
    stb0 = 1'b0; stb1 = 1'b0;
    #1;
    cmp_all("rst");
    step();
    cmp_all("rst_hold");
    rst0 = 1'b0; rst1 = 1'b0;
    en0  = 1'b1; en1  = 1'b1;
    step();
    chk("first_fs0", 32'(fs0), 32'd1);
    chk("first_ls0", 32'(ls0), 32'd1);
    chk("first_act0", 32'(act0), 32'd1);
    step();
    chk("second_x0", 32'(x0), 32'd1);
    chk("second_fs0", 32'(fs0), 32'd0);

    // Three full lines with en held high; small instance toggles en.
    for (int i = 0; i < 3 * T0_H + 20; i++) begin
      en1 = ~en1;
      if (pos0 == 2 * T0_H + 500) async_rst(1'b1, 1'b0);
      step();
    end

    // Randomised enables and occasional async resets.
    for (int i = 0; i < 4000; i++) begin
      en0 = ($urandom_range(0, 3) != 0);
      en1 = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 299) == 0)
        async_rst($urandom_range(0, 3) == 0, 1'b1);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
